// File: rtl/hud_pkg.sv
// Shared constants, state encoding and row-value packing for the HUD refresh scheduler.
package hud_pkg;

  localparam int unsigned NUM_ROWS = 6;
  localparam int unsigned ROW_W    = 3;
  localparam int unsigned VAL_W    = 16;
  localparam int unsigned KEY_W    = 8;
  localparam int unsigned NUM_KEYS = 4;

  localparam int unsigned ROW_FLOOR  = 0;
  localparam int unsigned ROW_HEALTH = 1;
  localparam int unsigned ROW_KEY0   = 2;
  localparam int unsigned ROW_KEY1   = 3;
  localparam int unsigned ROW_KEY2   = 4;
  localparam int unsigned ROW_KEY3   = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_SCAN  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

  typedef logic [NUM_ROWS-1:0][VAL_W-1:0] row_vals_t;

  // Spread the raw stat registers into one 16-bit value per row; key bytes zero-extended.
  function automatic row_vals_t pack_rows(input logic [VAL_W-1:0] floor_v,
                                          input logic [VAL_W-1:0] health_v,
                                          input logic [NUM_KEYS*KEY_W-1:0] keys_v);
    row_vals_t r;
    r             = '0;
    r[ROW_FLOOR]  = floor_v;
    r[ROW_HEALTH] = health_v;
    r[ROW_KEY0]   = VAL_W'(keys_v[0*KEY_W +: KEY_W]);
    r[ROW_KEY1]   = VAL_W'(keys_v[1*KEY_W +: KEY_W]);
    r[ROW_KEY2]   = VAL_W'(keys_v[2*KEY_W +: KEY_W]);
    r[ROW_KEY3]   = VAL_W'(keys_v[3*KEY_W +: KEY_W]);
    return r;
  endfunction

endpackage

// File: rtl/hud_dirty_pick.sv
// Lowest-index-first priority encoder over the HUD dirty vector.
module hud_dirty_pick
  import hud_pkg::*;
(
  input  logic [NUM_ROWS-1:0] dirty,
  output logic [ROW_W-1:0]    pick_row_c,
  output logic                pick_any_c
);

  // Walk downward so the lowest set bit is the last assignment to land.
  always_comb begin
    pick_row_c = '0;
    pick_any_c = 1'b0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (dirty[i]) begin
        pick_row_c = ROW_W'(i);
        pick_any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hud_refresh_sched.sv
// Per-frame HUD row redraw scheduler feeding the shared number renderer.
// Optional WAIT watchdog enabled by defining HUD_TIMEOUT_EN.
module hud_refresh_sched
  import hud_pkg::*;
(
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      vsync_pulse,
  input  logic [VAL_W-1:0]          floor,
  input  logic [VAL_W-1:0]          health,
  input  logic [NUM_KEYS*KEY_W-1:0] key_num,
  input  logic                      force_all,
  output logic                      job_valid,
  input  logic                      job_ready,
  output logic [ROW_W-1:0]          job_row,
  output logic [VAL_W-1:0]          job_value,
  input  logic                      job_done,
  output logic                      busy,
  output logic [7:0]                overrun_cnt,
  output logic                      err_timeout
);

  state_e               state_q, state_d;
  logic [NUM_ROWS-1:0]  dirty_q, dirty_d;
  row_vals_t            drawn_q, drawn_d;
  row_vals_t            snap_q, snap_d;
  logic                 force_pend_q, force_pend_d;
  logic                 vsync_pend_q, vsync_pend_d;
  logic [7:0]           overrun_q, overrun_d;
  logic                 job_valid_q, job_valid_d;
  logic [ROW_W-1:0]     job_row_q, job_row_d;
  logic [VAL_W-1:0]     job_value_q, job_value_d;
  logic                 busy_q, busy_d;
  logic [ROW_W-1:0]     pick_row_c;
  logic                 pick_any_c;
  logic                 timeout_hit_c;

  hud_dirty_pick u_pick (
    .dirty      (dirty_q),
    .pick_row_c (pick_row_c),
    .pick_any_c (pick_any_c)
  );

`ifdef HUD_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC = 4096;
  localparam int unsigned CNT_W       = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  // Counter idles at zero outside WAIT, so it starts from zero on every WAIT entry.
  always_comb begin
    wait_cnt_d    = (state_q == ST_WAIT) ? wait_cnt_q + CNT_W'(1) : '0;
    timeout_hit_c = (state_q == ST_WAIT) && !job_done &&
                    (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    err_d         = err_q | timeout_hit_c;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit_c = 1'b0;
  assign err_timeout   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    dirty_d      = dirty_q;
    drawn_d      = drawn_q;
    snap_d       = snap_q;
    force_pend_d = force_pend_q | force_all;
    vsync_pend_d = vsync_pend_q;
    overrun_d    = overrun_q;
    job_valid_d  = job_valid_q;
    job_row_d    = job_row_q;
    job_value_d  = job_value_q;

    // A frame start that arrives mid-frame is queued once and counted.
    if (vsync_pulse && (state_q != ST_IDLE)) begin
      vsync_pend_d = 1'b1;
      if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (vsync_pulse || vsync_pend_q) begin
          snap_d       = pack_rows(floor, health, key_num);
          vsync_pend_d = 1'b0;
          state_d      = ST_LATCH;
        end
      end
      ST_LATCH: begin
        for (int i = 0; i < NUM_ROWS; i++) begin
          if ((snap_q[i] != drawn_q[i]) || force_pend_q) dirty_d[i] = 1'b1;
        end
        force_pend_d = force_all;
        state_d      = ST_SCAN;
      end
      ST_SCAN: begin
        if (pick_any_c) begin
          job_row_d   = pick_row_c;
          job_value_d = snap_q[pick_row_c];
          job_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (job_ready) begin
          job_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (job_done) begin
          dirty_d[job_row_q] = 1'b0;
          drawn_d[job_row_q] = snap_q[job_row_q];
          state_d            = ST_SCAN;
        end else if (timeout_hit_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      dirty_q      <= {NUM_ROWS{1'b1}};
      drawn_q      <= '0;
      snap_q       <= '0;
      force_pend_q <= 1'b0;
      vsync_pend_q <= 1'b0;
      overrun_q    <= 8'd0;
      job_valid_q  <= 1'b0;
      job_row_q    <= '0;
      job_value_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dirty_q      <= dirty_d;
      drawn_q      <= drawn_d;
      snap_q       <= snap_d;
      force_pend_q <= force_pend_d;
      vsync_pend_q <= vsync_pend_d;
      overrun_q    <= overrun_d;
      job_valid_q  <= job_valid_d;
      job_row_q    <= job_row_d;
      job_value_q  <= job_value_d;
      busy_q       <= busy_d;
    end
  end

  assign job_valid   = job_valid_q;
  assign job_row     = job_row_q;
  assign job_value   = job_value_q;
  assign busy        = busy_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_hud_refresh_sched.sv
// Scoreboard bench for hud_refresh_sched: expected jobs queued by stimulus, popped on each accept.
module tb_hud_refresh_sched;

  logic        clk;
  logic        rstn;
  logic        vsync_pulse;
  logic [15:0] floor;
  logic [15:0] health;
  logic [31:0] key_num;
  logic        force_all;
  logic        job_valid;
  logic        job_ready;
  logic [2:0]  job_row;
  logic [15:0] job_value;
  logic        job_done;
  logic        busy;
  logic [7:0]  overrun_cnt;
  logic        err_timeout;

  typedef struct packed {
    logic [2:0]  row;
    logic [15:0] value;
  } job_t;

  job_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   done_dly = 5;
  bit   ready_en = 1'b1;
  bit   done_en  = 1'b1;

  hud_refresh_sched dut (
    .clk         (clk),
    .rstn        (rstn),
    .vsync_pulse (vsync_pulse),
    .floor       (floor),
    .health      (health),
    .key_num     (key_num),
    .force_all   (force_all),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_row     (job_row),
    .job_value   (job_value),
    .job_done    (job_done),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_job(input int row, input int value);
    job_t j;
    j.row   = 3'(row);
    j.value = 16'(value);
    exp_q.push_back(j);
  endtask

  task automatic pulse_vsync();
    @(posedge clk); #1 vsync_pulse = 1'b1;
    @(posedge clk); #1 vsync_pulse = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !busy && !job_valid && done_cnt == 0)) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        checks++;
        errors++;
        $display("FAIL %s: timeout, %0d jobs outstanding, busy=%0d", name, exp_q.size(), busy);
        return;
      end
    end
  endtask

  // Renderer model: ready follows ready_en, done pulses done_dly cycles after each accept.
  initial begin
    job_ready = 1'b0;
    job_done  = 1'b0;
    forever begin
      @(posedge clk); #1;
      job_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) job_done = 1'b1;
      end
      job_ready = ready_en;
    end
  end

  // Monitor: every accepted job is compared against the head of the scoreboard.
  initial begin
    job_t e;
    forever begin
      @(negedge clk);
      if (rstn && job_valid && job_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_job: got row %0d value %0d, expected none", job_row, job_value);
        end else begin
          e = exp_q.pop_front();
          chk("job_row", 32'(job_row), 32'(e.row));
          chk("job_value", 32'(job_value), 32'(e.value));
        end
        if (done_en) done_cnt = done_dly;
      end
    end
  end

  initial begin
    rstn        = 1'b0;
    vsync_pulse = 1'b0;
    floor       = 16'd0;
    health      = 16'd0;
    key_num     = 32'd0;
    force_all   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_job_valid", 32'(job_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun_cnt), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_job_row", 32'(job_row), 32'd0);
    chk("rst_job_value", 32'(job_value), 32'd0);
    #1 rstn = 1'b1;

    // Full first draw with latency check.
    floor   = 16'd3;
    health  = 16'd100;
    key_num = 32'h01020304;
    push_job(0, 3); push_job(1, 100); push_job(2, 4);
    push_job(3, 3); push_job(4, 2);   push_job(5, 1);
    pulse_vsync();
    @(negedge clk);
    chk("lat_latch_busy", 32'(busy), 32'd1);
    chk("lat_latch_valid", 32'(job_valid), 32'd0);
    @(negedge clk);
    chk("lat_scan_valid", 32'(job_valid), 32'd0);
    @(negedge clk);
    chk("lat_issue_valid", 32'(job_valid), 32'd1);
    wait_idle("full_draw", 200);
    @(negedge clk);
    chk("full_draw_busy", 32'(busy), 32'd0);

    // Only health changed.
    health = 16'd99;
    push_job(1, 99);
    pulse_vsync();
    wait_idle("health_only", 100);

    // Renderer stalls in ISSUE; job must hold steady.
    floor    = 16'd7;
    ready_en = 1'b0;
    push_job(0, 7);
    pulse_vsync();
    for (int i = 0; i < 20 && !job_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(job_valid), 32'd1);
      chk("stall_row", 32'(job_row), 32'd0);
      chk("stall_value", 32'(job_value), 32'd7);
      @(negedge clk);
    end
    ready_en = 1'b1;
    wait_idle("stall", 100);

    // Two frame starts during WAIT; pending frame begins without another vsync.
    done_dly = 20;
    floor    = 16'd8;
    push_job(0, 8);
    pulse_vsync();
    repeat (5) @(posedge clk);
    pulse_vsync();
    pulse_vsync();
    health = 16'd50;
    push_job(1, 50);
    wait_idle("overrun", 200);
    chk("overrun_cnt", 32'(overrun_cnt), 32'd2);
    done_dly = 5;

    // Forced redraw with unchanged values.
    @(posedge clk); #1 force_all = 1'b1;
    @(posedge clk); #1 force_all = 1'b0;
    push_job(0, 8); push_job(1, 50); push_job(2, 4);
    push_job(3, 3); push_job(4, 2);  push_job(5, 1);
    pulse_vsync();
    wait_idle("force_all", 300);
    chk("force_overrun_cnt", 32'(overrun_cnt), 32'd2);

`ifdef HUD_TIMEOUT_EN
    done_en = 1'b0;
    floor   = 16'd10;
    push_job(0, 10);
    pulse_vsync();
    for (int i = 0; i < 5000 && !err_timeout; i++) @(negedge clk);
    @(negedge clk);
    chk("timeout_err", 32'(err_timeout), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    done_en = 1'b1;
    push_job(0, 10);
    pulse_vsync();
    wait_idle("timeout_retry", 100);
    chk("timeout_sticky", 32'(err_timeout), 32'd1);
`else
    chk("no_timeout_err", 32'(err_timeout), 32'd0);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
